// File: rtl/serial_parity_checker.sv
// serial_parity_checker: receive-side deserialiser for framed serial data.
// A frame is DATA_WIDTH data bits (LSB first) followed by one parity bit.
// The recovered word is presented with a per-frame parity error flag and
// a saturating count of bad frames.
module serial_parity_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_ODD = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    input  logic                  sof,
    input  logic                  clear_count,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_ready,
    output logic                  parity_error,
    output logic                  frame_abort,
    output logic [CNT_WIDTH-1:0]  err_count
);

    // Bit counter must be able to hold DATA_WIDTH itself.
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    // A one-bit word has no DATA phase: bit 0 is followed directly by parity.
    localparam state_t              AFTER_FIRST = (DATA_WIDTH == 1) ? PARITY : DATA;
    localparam logic [BW-1:0]       LAST_IDX    = BW'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic                ODD         = 1'(PARITY_ODD);

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic [BW-1:0]          cnt_q;
    logic [DATA_WIDTH-1:0]  data_out_q;
    logic                   data_ready_q;
    logic                   parity_error_q;
    logic                   frame_abort_q;
    logic [CNT_WIDTH-1:0]   err_count_q;

    logic par_err_d;
    logic frame_done_d;

    // Parity bit arriving now completes the frame; sof always takes priority.
    assign par_err_d    = ((^shift_q) ^ bit_in) != ODD;
    assign frame_done_d = (state_q == PARITY) && bit_valid && !sof;

    // Framing FSM with registered word, status and one-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            cnt_q          <= '0;
            data_out_q     <= '0;
            data_ready_q   <= 1'b0;
            parity_error_q <= 1'b0;
            frame_abort_q  <= 1'b0;
        end else begin
            data_ready_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            if (bit_valid) begin
                if (sof) begin
                    // Restart; anything in flight is dropped and flagged.
                    shift_q       <= DATA_WIDTH'(bit_in);
                    cnt_q         <= BW'(1);
                    state_q       <= AFTER_FIRST;
                    frame_abort_q <= (state_q != IDLE);
                end else begin
                    case (state_q)
                        IDLE: ; // stray bits outside a frame are discarded
                        DATA: begin
                            shift_q <= shift_q | (DATA_WIDTH'(bit_in) << cnt_q);
                            cnt_q   <= cnt_q + BW'(1);
                            if (cnt_q == LAST_IDX) state_q <= PARITY;
                        end
                        PARITY: begin
                            data_out_q     <= shift_q;
                            parity_error_q <= par_err_d;
                            data_ready_q   <= 1'b1;
                            cnt_q          <= '0;
                            state_q        <= IDLE;
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    // Saturating bad-frame counter; a clear overrides a coincident increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= '0;
        end else if (clear_count) begin
            err_count_q <= '0;
        end else if (frame_done_d && par_err_d && (err_count_q != CNT_MAX)) begin
            err_count_q <= err_count_q + CNT_WIDTH'(1);
        end
    end

    assign data_out     = data_out_q;
    assign data_ready   = data_ready_q;
    assign parity_error = parity_error_q;
    assign frame_abort  = frame_abort_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: three instances (8-bit even with a 2-bit
// counter, 8-bit odd, 1-bit even) share one serial stream. A frame-level
// model queues expected pulses; a negedge monitor pops and compares them.
module tb_serial_parity_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, bit_in, bit_valid, sof, clear_count;

    logic [7:0] do0, do1;
    logic       do2;
    logic       rdy0, rdy1, rdy2, pe0, pe1, pe2, ab0, ab1, ab2;
    logic [1:0] ec0;
    logic [7:0] ec1;
    logic [2:0] ec2;

    serial_parity_checker #(.DATA_WIDTH(8), .PARITY_ODD(0), .CNT_WIDTH(2)) u0 (
        .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .sof(sof), .clear_count(clear_count), .data_out(do0), .data_ready(rdy0),
        .parity_error(pe0), .frame_abort(ab0), .err_count(ec0));

    serial_parity_checker #(.DATA_WIDTH(8), .PARITY_ODD(1), .CNT_WIDTH(8)) u1 (
        .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .sof(sof), .clear_count(clear_count), .data_out(do1), .data_ready(rdy1),
        .parity_error(pe1), .frame_abort(ab1), .err_count(ec1));

    serial_parity_checker #(.DATA_WIDTH(1), .PARITY_ODD(0), .CNT_WIDTH(3)) u2 (
        .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .sof(sof), .clear_count(clear_count), .data_out(do2), .data_ready(rdy2),
        .parity_error(pe2), .frame_abort(ab2), .err_count(ec2));

    typedef struct {
        bit          abort;
        logic [31:0] data;
        bit          perr;
        int          cnt;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int checks = 0;
    int failures = 0;

    // Frame-level model state per instance.
    int          mw[3]   = '{8, 8, 1};
    int          modd[3] = '{0, 1, 0};
    int          mmax[3] = '{3, 255, 7};
    bit          infr[3];
    int          flen[3];
    logic [31:0] fword[3];
    logic [31:0] last_data[3];
    bit          last_perr[3];
    int          ecnt[3];

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            infr[d] = 0; flen[d] = 0; fword[d] = '0;
            last_data[d] = '0; last_perr[d] = 0; ecnt[d] = 0;
        end
    endtask

    task automatic push(int d, exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // One sampled cycle of stimulus as seen by each receiver.
    task automatic model_step(bit v, bit s, bit b, bit clr);
        for (int d = 0; d < 3; d++) begin
            bit rdy, ab, pe;
            exp_t e;
            rdy = 0; ab = 0; pe = 0;
            if (v) begin
                if (s) begin
                    ab = infr[d];
                    infr[d] = 1;
                    fword[d] = '0;
                    fword[d][0] = b;
                    flen[d] = 1;
                end else if (infr[d]) begin
                    if (flen[d] < mw[d]) begin
                        fword[d][flen[d]] = b;
                        flen[d]++;
                    end else begin
                        pe = ((($countones(fword[d]) + int'(b)) % 2) != modd[d]);
                        rdy = 1;
                        infr[d] = 0;
                        last_data[d] = fword[d];
                        last_perr[d] = pe;
                    end
                end
            end
            if (clr) ecnt[d] = 0;
            else if (rdy && pe && ecnt[d] < mmax[d]) ecnt[d]++;
            if (rdy || ab) begin
                e.abort = ab; e.data = last_data[d]; e.perr = last_perr[d]; e.cnt = ecnt[d];
                push(d, e);
            end
        end
    endtask

    task automatic mon(int d, logic r, logic a, logic [31:0] dat, logic pe, logic [31:0] ec);
        exp_t e;
        bit got;
        if (r || a) begin
            chk($sformatf("d%0d_ready_abort_exclusive", d), 32'(r & a), 32'd0);
            got = 0;
            case (d)
                0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1; end
            endcase
            if (!got) begin
                checks++; failures++;
                $display("FAIL d%0d_unexpected_pulse actual ready=%0b abort=%0b required none", d, r, a);
            end else begin
                chk($sformatf("d%0d_kind_abort", d), 32'(a), 32'(e.abort));
                chk($sformatf("d%0d_data_out", d), dat, e.data);
                chk($sformatf("d%0d_parity_error", d), 32'(pe), 32'(e.perr));
                chk($sformatf("d%0d_err_count", d), ec, 32'(e.cnt));
            end
        end
    endtask

    // Monitor: outputs change at posedge, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            mon(0, rdy0, ab0, 32'(do0), pe0, 32'(ec0));
            mon(1, rdy1, ab1, 32'(do1), pe1, 32'(ec1));
            mon(2, rdy2, ab2, 32'(do2), pe2, 32'(ec2));
        end
    end

    task automatic drive(bit v, bit s, bit b, bit clr);
        @(posedge clk);
        #1;
        bit_valid = v; sof = s; bit_in = b; clear_count = clr;
        model_step(v, s, b, clr);
    endtask

    task automatic idle_gap(int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic send_frame(logic [7:0] w, bit p, int gap, bit clr_last);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, i == 0, (i < 8) ? w[i] : p, (i == 8) && clr_last);
            if (i < 8) idle_gap(gap);
        end
    endtask

    task automatic send_bits(logic [7:0] w, int n);
        for (int i = 0; i < n; i++) drive(1'b1, i == 0, w[i], 1'b0);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_d0_data"},  32'(do0), 0); chk({tag, "_d0_rdy"}, 32'(rdy0), 0);
        chk({tag, "_d0_perr"},  32'(pe0), 0); chk({tag, "_d0_abort"}, 32'(ab0), 0);
        chk({tag, "_d0_cnt"},   32'(ec0), 0);
        chk({tag, "_d1_data"},  32'(do1), 0); chk({tag, "_d1_rdy"}, 32'(rdy1), 0);
        chk({tag, "_d1_perr"},  32'(pe1), 0); chk({tag, "_d1_abort"}, 32'(ab1), 0);
        chk({tag, "_d1_cnt"},   32'(ec1), 0);
        chk({tag, "_d2_data"},  32'(do2), 0); chk({tag, "_d2_rdy"}, 32'(rdy2), 0);
        chk({tag, "_d2_perr"},  32'(pe2), 0); chk({tag, "_d2_abort"}, 32'(ab2), 0);
        chk({tag, "_d2_cnt"},   32'(ec2), 0);
    endtask

    initial begin
        reset_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0; clear_count = 1'b0;
        model_reset();
        #1;
        chk_all_zero("reset");
        #11 reset_n = 1'b1;

        // Basic even frame, then error and good frames.
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        send_frame(8'h01, 1'b0, 0, 1'b0);
        send_frame(8'h03, 1'b0, 0, 1'b0);
        // Odd-parity cases, gap-free and with 3-cycle valid gaps.
        send_frame(8'h00, 1'b1, 0, 1'b0);
        send_frame(8'h00, 1'b0, 0, 1'b0);
        send_frame(8'h00, 1'b1, 3, 1'b0);
        send_frame(8'h00, 1'b0, 3, 1'b0);
        // Abort during DATA, then a good frame.
        send_bits(8'h5A, 4);
        send_frame(8'h3C, 1'b0, 0, 1'b0);
        // Abort during PARITY: data_out must keep 3C.
        send_bits(8'h5A, 8);
        send_frame(8'hC3, 1'b0, 0, 1'b0);
        // Saturation on the 2-bit counter, then clear coinciding with a bad frame.
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) send_frame(8'h01, 1'b0, 0, 1'b0);
        send_frame(8'h01, 1'b0, 0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h07, 1'b0, 0, 1'b0);

        // Reset mid-frame after 5 data bits.
        send_bits(8'hFF, 5);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        chk("q_empty_at_reset", 32'(q0.size() + q1.size() + q2.size()), 0);
        model_reset();
        #20 reset_n = 1'b1;
        send_frame(8'hFF, 1'b0, 0, 1'b0);

        // Randomised stream.
        for (int k = 0; k < 600; k++)
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 1'b0);

        chk("d0_q_drained", 32'(q0.size()), 0);
        chk("d1_q_drained", 32'(q1.size()), 0);
        chk("d2_q_drained", 32'(q2.size()), 0);
        chk("d0_final_cnt", 32'(ec0), 32'(ecnt[0]));
        chk("d1_final_cnt", 32'(ec1), 32'(ecnt[1]));
        chk("d2_final_cnt", 32'(ec2), 32'(ecnt[2]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
